// File: rtl/irq_ctrl_pkg.sv
// Shared widths and FSM state encoding for the 16-source interrupt controller.
package irq_ctrl_pkg;

  localparam int NUM_SRC = 16;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc16.sv
// Combinational 16:4 priority encoder; the highest set index wins.
module irq_prio_enc16
  import irq_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_controller16.sv
// Edge-captured, masked interrupt sequencer presenting one source at a time
// through a valid/ack handshake and holding it until end-of-interrupt.
module irq_priority_controller16
  import irq_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_n,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack,
  input  logic               eoi,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               overrun
);

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pending_nxt;
  logic               overrun_nxt;
  logic [ID_W-1:0]    enc_id;
  logic               enc_valid;
  logic [ID_W-1:0]    id_nxt;
  state_t             state;
  state_t             state_nxt;

  irq_prio_enc16 u_enc (
    .req   (cand),
    .id    (enc_id),
    .valid (enc_valid)
  );

  // Pending update: an edge arriving in the ack cycle re-arms the bit.
  always_comb begin
    edges = irq & ~irq_q;
    cand  = pending & ~mask;
    clr   = '0;
    if (state == PRESENT && ack) clr[irq_id] = 1'b1;
    pending_nxt = (pending & ~clr) | edges;
    overrun_nxt = |(edges & pending & ~clr);
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    unique case (state)
      IDLE: begin
        if (!enable_n && enc_valid) begin
          state_nxt = PRESENT;
          id_nxt    = enc_id;
        end
      end
      PRESENT: begin
        if (ack)           state_nxt = SERVICE;
        else if (enable_n) state_nxt = IDLE;
      end
      SERVICE: begin
        if (eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sampling irq during reset keeps lines already high from looking like edges.
  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      irq_id    <= '0;
      irq_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      irq_id    <= id_nxt;
      irq_valid <= (state_nxt == PRESENT);
      busy      <= (state_nxt == SERVICE);
      overrun   <= overrun_nxt;
    end
  end

endmodule
